// File: rtl/ibex_fetch_queue.sv
// Instruction fetch queue: word fetch, outstanding tracking, 16/32-bit realignment (RVC via FETCH_QUEUE_RVC_EN).
// Latency: rvalid -> valid_o one cycle (registered FIFO write); branch -> request at target next cycle.
// Backpressure: holds instruction while ready=0; stops requesting once FIFO plus in-flight words fill DEPTH.
module ibex_fetch_queue #(
    parameter int unsigned DEPTH           = 3,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 5;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0]   mem_q [DEPTH];
    ptr_t          rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, outstanding_q, discard_q;
    logic [CW-1:0] outstanding_d, discard_d;
    logic [31:0]   fetch_addr_q, stale_addr_q, addr_q;
    logic          held_q, stale_q;

    logic          issue_ok, grant, push, pop, handshake;
    logic          avail, pop_en;
    logic [31:0]   head_w, instr;
    logic [2:0]    step;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 1'b1);
    endfunction

    // A request that saw a branch before its grant is "stale": it keeps its old address and its data is dropped.
    assign issue_ok     = req_i && ((count_q + outstanding_q) < CW'(DEPTH))
                                && (outstanding_q < CW'(MAX_OUTSTANDING));
    assign instr_req_o  = held_q | issue_ok;
    assign instr_addr_o = stale_q ? stale_addr_q : fetch_addr_q;
    assign grant        = instr_req_o & instr_gnt_i;
    assign busy_o       = instr_req_o | (outstanding_q != '0);

    assign outstanding_d = outstanding_q + CW'(grant) - CW'(instr_rvalid_i);
    assign discard_d     = discard_q + CW'(grant && stale_q)
                                     - CW'(instr_rvalid_i && (discard_q != '0));
    assign push          = instr_rvalid_i && (discard_q == '0) && !branch_i;

    assign head_w = mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_RVC_EN
    logic        offset_q, offset_adv;
    logic [31:0] next_w;
    logic        unused_next;

    assign next_w      = mem_q[ptr_inc(rd_ptr_q)];
    assign unused_next = ^next_w[31:16];

    always_comb begin
        avail      = 1'b0;
        instr      = head_w;
        step       = 3'd4;
        pop_en     = 1'b1;
        offset_adv = offset_q;
        if (!offset_q) begin
            avail = (count_q != '0);
            if (head_w[1:0] != 2'b11) begin
                instr      = {16'h0000, head_w[15:0]};
                step       = 3'd2;
                pop_en     = 1'b0;
                offset_adv = 1'b1;
            end
        end else if (head_w[17:16] != 2'b11) begin
            avail      = (count_q != '0);
            instr      = {16'h0000, head_w[31:16]};
            step       = 3'd2;
            offset_adv = 1'b0;
        end else begin
            // 32-bit instruction straddling two words: wait for the next word too.
            avail = (count_q >= CW'(2));
            instr = {next_w[15:0], head_w[31:16]};
        end
    end
`else
    logic unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign avail       = (count_q != '0);
    assign instr       = head_w;
    assign step        = 3'd4;
    assign pop_en      = 1'b1;
`endif

    assign valid_o   = avail && !branch_i;
    assign rdata_o   = instr;
    assign addr_o    = addr_q;
    assign handshake = valid_o && ready_i;
    assign pop       = handshake && pop_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_addr_q  <= '0;
            stale_addr_q  <= '0;
            addr_q        <= '0;
            held_q        <= 1'b0;
            stale_q       <= 1'b0;
`ifdef FETCH_QUEUE_RVC_EN
            offset_q      <= 1'b0;
`endif
        end else begin
            outstanding_q <= outstanding_d;
            held_q        <= instr_req_o & ~instr_gnt_i;
            if (branch_i) begin
                fetch_addr_q <= {addr_i[31:2], 2'b00};
                stale_q      <= instr_req_o & ~instr_gnt_i;
                stale_addr_q <= instr_addr_o;
                discard_q    <= outstanding_d;
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                count_q      <= '0;
`ifdef FETCH_QUEUE_RVC_EN
                addr_q       <= addr_i;
                offset_q     <= addr_i[1];
`else
                addr_q       <= {addr_i[31:2], 2'b00};
`endif
            end else begin
                discard_q <= discard_d;
                if (grant) stale_q <= 1'b0;
                if (grant && !stale_q) fetch_addr_q <= fetch_addr_q + 32'd4;
                if (push) begin
                    mem_q[wr_ptr_q] <= instr_rdata_i;
                    wr_ptr_q        <= ptr_inc(wr_ptr_q);
                end
                if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
                count_q <= count_q + CW'(push) - CW'(pop);
                if (handshake) begin
                    addr_q <= addr_q + {29'b0, step};
`ifdef FETCH_QUEUE_RVC_EN
                    offset_q <= offset_adv;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ibex_fetch_queue.sv
// Directed bench for ibex_fetch_queue with a simple in-order instruction memory model.
module tb_ibex_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0, branch_i = 1'b0, ready_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        valid_o, instr_req_o, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o;
    logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] pend_q[$];
    logic [31:0] grant_log[$];
    int gnt_wait = 0;
    int req_cycles = 0;
    bit resp_en = 1'b1;

    ibex_fetch_queue #(.DEPTH(3), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
        .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0080: return 32'h0000_0013;
            32'h0000_0100: return 32'h0513_0001;
            32'h0000_0104: return 32'h1234_00B5;
            32'h0000_0200: return 32'h4585_4501;
            default:       return a ^ 32'hABC0_0003;
        endcase
    endfunction

    // Memory: grant after gnt_wait cycles of request, answer in order one cycle after grant.
    always @(negedge clk) begin
        #2;
        instr_gnt_i = instr_req_o && (req_cycles >= gnt_wait);
        if (resp_en && pend_q.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(pend_q.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (instr_req_o && instr_gnt_i) begin
                pend_q.push_back(instr_addr_o);
                grant_log.push_back(instr_addr_o);
                req_cycles = 0;
            end else if (instr_req_o) begin
                req_cycles = req_cycles + 1;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0; addr_i = '0;
        pend_q.delete(); grant_log.delete();
        gnt_wait = 0; req_cycles = 0; resp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge starting the cycle after the branch, grant log cleared.
    task automatic do_branch(input logic [31:0] a);
        @(negedge clk);
        branch_i = 1'b1; addr_i = a; req_i = 1'b0;
        @(negedge clk);
        branch_i = 1'b0;
        grant_log.delete();
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #4;
        n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", instr_req_o); end
        n_cmp++; if (instr_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", instr_addr_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        n_cmp++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_straight;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h0000_0013; exp_d[1] = 32'hABC0_0087;
        exp_d[2] = 32'hABC0_008B; exp_d[3] = 32'hABC0_008F;
        do_reset();
        do_branch(32'h80);
        req_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            #4;
            if (c == 1) begin
                n_cmp++; if (instr_req_o !== 1'b1) begin n_fail++; $display("FAIL straight_req: got %b want 1", instr_req_o); end
                n_cmp++; if (instr_addr_o !== 32'h80) begin n_fail++; $display("FAIL straight_iaddr: got %h want 00000080", instr_addr_o); end
            end
            n_cmp++; if (valid_o !== (c >= 3)) begin n_fail++; $display("FAIL straight_valid c%0d: got %b want %b", c, valid_o, (c >= 3)); end
            if (c >= 3) begin
                n_cmp++; if (rdata_o !== exp_d[c-3]) begin n_fail++; $display("FAIL straight_rdata c%0d: got %h want %h", c, rdata_o, exp_d[c-3]); end
                n_cmp++; if (addr_o !== 32'h80 + 32'(4 * (c - 3))) begin n_fail++; $display("FAIL straight_addr c%0d: got %h want %h", c, addr_o, 32'h80 + 32'(4 * (c - 3))); end
            end
        end
        n_cmp++;
        if (grant_log.size() < 3) begin n_fail++; $display("FAIL straight_grants: got %0d grants want >=3", grant_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (grant_log[i] !== 32'h80 + 32'(4 * i)) begin n_fail++; $display("FAIL straight_gaddr %0d: got %h want %h", i, grant_log[i], 32'h80 + 32'(4 * i)); end
            end
        end
        req_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_full;
        do_reset();
        do_branch(32'h80);
        req_i = 1'b1; ready_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            #4;
        end
        n_cmp++; if (grant_log.size() != 3) begin n_fail++; $display("FAIL full_grants: got %0d want 3", grant_log.size()); end
        n_cmp++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b want 0", instr_req_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %b want 0", busy_o); end
        n_cmp++; if (valid_o !== 1'b1 || rdata_o !== 32'h13 || addr_o !== 32'h80) begin
            n_fail++; $display("FAIL full_hold: got v=%b d=%h a=%h want v=1 d=00000013 a=00000080", valid_o, rdata_o, addr_o); end
        @(negedge clk);
        ready_i = 1'b1;
        #4;
        @(negedge clk);
        ready_i = 1'b0;
        #4;
        n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h8C) begin
            n_fail++; $display("FAIL full_resume: got req=%b a=%h want req=1 a=0000008c", instr_req_o, instr_addr_o); end
        n_cmp++; if (addr_o !== 32'h84) begin n_fail++; $display("FAIL full_addr_after_pop: got %h want 00000084", addr_o); end
        req_i = 1'b0;
    endtask

    task automatic test_branch_outstanding;
        do_reset();
        do_branch(32'h80);
        resp_en = 1'b0; req_i = 1'b1; ready_i = 1'b1;
        #4;
        @(negedge clk); #4;
        @(negedge clk);
        branch_i = 1'b1; addr_i = 32'h300;
        #4;
        n_cmp++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL bo_inflight: got req=%b busy=%b want req=0 busy=1", instr_req_o, busy_o); end
        @(negedge clk);
        branch_i = 1'b0; resp_en = 1'b1;
        grant_log.delete();
        #4;
        for (int k = 0; k < 12 && valid_o !== 1'b1; k++) begin @(negedge clk); #4; end
        n_cmp++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bo_timeout: valid_o got %b want 1", valid_o); end
        else if (rdata_o !== 32'hABC0_0303 || addr_o !== 32'h300) begin
            n_fail++; $display("FAIL bo_first: got d=%h a=%h want d=abc00303 a=00000300", rdata_o, addr_o); end
        n_cmp++; if (grant_log.size() == 0 || grant_log[0] !== 32'h300) begin
            n_fail++; $display("FAIL bo_gaddr: got %0d grants want first at 00000300", grant_log.size()); end
        req_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_gnt_delay;
        do_reset();
        do_branch(32'h80);
        gnt_wait = 3; req_i = 1'b1; ready_i = 1'b1;
        #4;
        n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            n_fail++; $display("FAIL gd_c1: got req=%b a=%h want req=1 a=00000080", instr_req_o, instr_addr_o); end
        @(negedge clk);
        branch_i = 1'b1; addr_i = 32'h400;
        #4;
        n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            n_fail++; $display("FAIL gd_c2: got req=%b a=%h want req=1 a=00000080", instr_req_o, instr_addr_o); end
        @(negedge clk);
        branch_i = 1'b0; gnt_wait = 0;
        #4;
        n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            n_fail++; $display("FAIL gd_c3: got req=%b a=%h want req=1 a=00000080", instr_req_o, instr_addr_o); end
        @(negedge clk); #4;
        n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400) begin
            n_fail++; $display("FAIL gd_c4: got req=%b a=%h want req=1 a=00000400", instr_req_o, instr_addr_o); end
        for (int k = 0; k < 12 && valid_o !== 1'b1; k++) begin @(negedge clk); #4; end
        n_cmp++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL gd_timeout: valid_o got %b want 1", valid_o); end
        else if (rdata_o !== 32'hABC0_0403 || addr_o !== 32'h400) begin
            n_fail++; $display("FAIL gd_first: got d=%h a=%h want d=abc00403 a=00000400", rdata_o, addr_o); end
        n_cmp++; if (grant_log.size() < 2 || grant_log[0] !== 32'h80 || grant_log[1] !== 32'h400) begin
            n_fail++; $display("FAIL gd_grants: got %0d grants want 00000080 then 00000400", grant_log.size()); end
        req_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_branch_beats_ready;
        logic [31:0] exp_a, exp_d;
`ifdef FETCH_QUEUE_RVC_EN
        exp_a = 32'h502; exp_d = 32'h0000_ABC0;
`else
        exp_a = 32'h500; exp_d = 32'hABC0_0503;
`endif
        do_reset();
        do_branch(32'h80);
        req_i = 1'b1; ready_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #4;
        end
        @(negedge clk);
        branch_i = 1'b1; addr_i = 32'h502; ready_i = 1'b1;
        #4;
        n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bbr_valid: got %b want 0", valid_o); end
        @(negedge clk);
        branch_i = 1'b0;
        #4;
        n_cmp++; if (addr_o !== exp_a) begin n_fail++; $display("FAIL bbr_addr: got %h want %h", addr_o, exp_a); end
        for (int k = 0; k < 12 && valid_o !== 1'b1; k++) begin @(negedge clk); #4; end
        n_cmp++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bbr_timeout: valid_o got %b want 1", valid_o); end
        else if (rdata_o !== exp_d || addr_o !== exp_a) begin
            n_fail++; $display("FAIL bbr_first: got d=%h a=%h want d=%h a=%h", rdata_o, addr_o, exp_d, exp_a); end
        req_i = 1'b0; ready_i = 1'b0;
    endtask

`ifdef FETCH_QUEUE_RVC_EN
    task automatic test_unaligned;
        do_reset();
        do_branch(32'h102);
        req_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #4;
            if (c == 3) begin
                n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ua_wait_next: got %b want 0", valid_o); end
            end
            if (c == 4) begin
                n_cmp++; if (valid_o !== 1'b1 || rdata_o !== 32'h00B5_0513 || addr_o !== 32'h102) begin
                    n_fail++; $display("FAIL ua_straddle: got v=%b d=%h a=%h want v=1 d=00b50513 a=00000102", valid_o, rdata_o, addr_o); end
            end
            if (c == 5) begin
                n_cmp++; if (valid_o !== 1'b1 || rdata_o !== 32'h0000_1234 || addr_o !== 32'h106) begin
                    n_fail++; $display("FAIL ua_next: got v=%b d=%h a=%h want v=1 d=00001234 a=00000106", valid_o, rdata_o, addr_o); end
            end
        end
        req_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_compressed;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000_4501; exp_d[1] = 32'h0000_4585; exp_d[2] = 32'hABC0_0207;
        do_reset();
        do_branch(32'h200);
        req_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #4;
            if (c >= 3) begin
                n_cmp++; if (valid_o !== 1'b1 || rdata_o !== exp_d[c-3] || addr_o !== 32'h200 + 32'(2 * (c - 3))) begin
                    n_fail++; $display("FAIL rvc_pair c%0d: got v=%b d=%h a=%h want v=1 d=%h a=%h", c, valid_o, rdata_o, addr_o, exp_d[c-3], 32'h200 + 32'(2 * (c - 3))); end
            end
        end
        req_i = 1'b0; ready_i = 1'b0;
    endtask
`else
    task automatic test_word_only;
        do_reset();
        do_branch(32'h202);
        req_i = 1'b1; ready_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            #4;
            if (c == 3) begin
                n_cmp++; if (valid_o !== 1'b1 || rdata_o !== 32'h4585_4501 || addr_o !== 32'h200) begin
                    n_fail++; $display("FAIL word_first: got v=%b d=%h a=%h want v=1 d=45854501 a=00000200", valid_o, rdata_o, addr_o); end
            end
            if (c == 4) begin
                n_cmp++; if (valid_o !== 1'b1 || rdata_o !== 32'hABC0_0207 || addr_o !== 32'h204) begin
                    n_fail++; $display("FAIL word_second: got v=%b d=%h a=%h want v=1 d=abc00207 a=00000204", valid_o, rdata_o, addr_o); end
            end
        end
        req_i = 1'b0; ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_straight();
        test_full();
        test_branch_outstanding();
        test_gnt_delay();
        test_branch_beats_ready();
`ifdef FETCH_QUEUE_RVC_EN
        test_unaligned();
        test_compressed();
`else
        test_word_only();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
